// File: rtl/stack_arbiter_if.sv
// Requester-side bus of the stack arbiter: per-requester push/pop requests, the
// one-hot grant, and the registered pop response.
interface stack_arbiter_if #(
   parameter int DATA = 64,
   parameter int REQ  = 4,
   parameter int IDW  = $clog2(REQ)
);
   logic [REQ-1:0]      req_push;
   logic [REQ-1:0]      req_pop;
   logic [REQ*DATA-1:0] req_wd;
   logic [REQ-1:0]      req_gnt;
   logic                resp_valid;
   logic [IDW-1:0]      resp_id;
   logic [DATA-1:0]     resp_data;
   logic                resp_err;

   modport master (
      output req_push, req_pop, req_wd,
      input  req_gnt, resp_valid, resp_id, resp_data, resp_err
   );

   modport slave (
      input  req_push, req_pop, req_wd,
      output req_gnt, resp_valid, resp_id, resp_data, resp_err
   );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one single-push/single-pop LIFO among REQ clients;
// tracks occupancy locally and returns popped data one cycle after the grant.
module stack_arbiter #(
   parameter int DATA  = 64,
   parameter int DEPTH = 8,
   parameter int REQ   = 4,
   parameter int IDW   = $clog2(REQ),
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   stack_arbiter_if.slave  bus,
   output logic [CW-1:0]   occ,
   output logic            stk_flush_,
   output logic            stk_push_,
   output logic [DATA-1:0] stk_wd,
   output logic            stk_pop_,
   input  logic [DATA-1:0] stk_rd,
   input  logic            stk_v,
   input  logic            stk_busy
);

   logic [CW-1:0]   r_occ;
   logic [IDW-1:0]  r_rr_ptr;
   logic            r_vld_p1;
   logic [IDW-1:0]  r_id_p1;
   logic [DATA-1:0] r_data_p1;
   logic            r_err_p1;

   logic [DATA-1:0] w_wd [REQ];
   logic [REQ-1:0]  w_elig;
   logic            w_can_push;
   logic            w_found;
   logic            w_gnt;
   logic            w_is_push;
   logic            w_pop_ok;
   logic [IDW-1:0]  w_idx;
   logic [IDW-1:0]  w_rr_next;

   assign w_can_push = (r_occ < CW'(DEPTH)) && !stk_busy;

   // A requester asserting both push and pop is treated as a push this round.
   genvar g;
   generate
      for (g = 0; g < REQ; g++) begin : g_req
         assign w_wd[g]   = bus.req_wd[g*DATA +: DATA];
         assign w_elig[g] = bus.req_push[g] ? w_can_push : bus.req_pop[g];
      end
   endgenerate

   always_comb begin
      int             c;
      logic [IDW-1:0] cand;
      w_found = 1'b0;
      w_idx   = '0;
      c       = 0;
      cand    = '0;
      for (int k = 0; k < REQ; k++) begin
         c = int'(r_rr_ptr) + k;
         if (c >= REQ) c = c - REQ;
         cand = IDW'(c);
         if (!w_found && w_elig[cand]) begin
            w_found = 1'b1;
            w_idx   = cand;
         end
      end
   end

   assign w_gnt     = w_found && !reset && !flush;
   assign w_is_push = bus.req_push[w_idx];
   assign w_pop_ok  = (r_occ != '0);
   assign w_rr_next = (w_idx == IDW'(REQ-1)) ? '0 : w_idx + 1'b1;

   assign bus.req_gnt = w_gnt ? (REQ'(1) << w_idx) : '0;
   assign stk_push_   = !(w_gnt && w_is_push);
   assign stk_pop_    = !(w_gnt && !w_is_push && w_pop_ok);
   assign stk_flush_  = !(flush && !reset);
   assign stk_wd      = w_wd[w_idx];

   // p0 -> p1: grant cycle to registered pop response
   always_ff @(posedge clk) begin
      if (reset) begin
         r_occ     <= '0;
         r_rr_ptr  <= '0;
         r_vld_p1  <= 1'b0;
         r_id_p1   <= '0;
         r_data_p1 <= '0;
         r_err_p1  <= 1'b0;
      end else if (flush) begin
         r_occ    <= '0;
         r_vld_p1 <= 1'b0;
      end else begin
         r_vld_p1 <= 1'b0;
         if (w_gnt) begin
            r_rr_ptr <= w_rr_next;
            if (w_is_push) begin
               r_occ <= r_occ + 1'b1;
            end else begin
               r_vld_p1 <= 1'b1;
               r_id_p1  <= w_idx;
               // Underflowing pops still answer, so the requester is released.
               if (w_pop_ok) begin
                  r_occ     <= r_occ - 1'b1;
                  r_data_p1 <= stk_rd;
                  r_err_p1  <= ~stk_v;
               end else begin
                  r_data_p1 <= '0;
                  r_err_p1  <= 1'b1;
               end
            end
         end
      end
   end

   assign occ            = r_occ;
   assign bus.resp_valid = r_vld_p1;
   assign bus.resp_id    = r_id_p1;
   assign bus.resp_data  = r_data_p1;
   assign bus.resp_err   = r_err_p1;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a small behavioural LIFO on the stack side.
module tb_stack_arbiter;
   localparam int DATA  = 64;
   localparam int DEPTH = 8;
   localparam int REQ   = 4;
   localparam int CW    = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;
   logic            stk_busy;
   logic [CW-1:0]   occ;
   logic            stk_flush_;
   logic            stk_push_;
   logic            stk_pop_;
   logic [DATA-1:0] stk_wd;
   logic [DATA-1:0] stk_rd;
   logic            stk_v;
   logic [DATA-1:0] wd [REQ];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stack_arbiter_if #(.DATA(DATA), .REQ(REQ)) bus ();
   assign bus.req_wd = {wd[3], wd[2], wd[1], wd[0]};

   stack_arbiter #(.DATA(DATA), .DEPTH(DEPTH), .REQ(REQ)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .bus        (bus),
      .occ        (occ),
      .stk_flush_ (stk_flush_),
      .stk_push_  (stk_push_),
      .stk_wd     (stk_wd),
      .stk_pop_   (stk_pop_),
      .stk_rd     (stk_rd),
      .stk_v      (stk_v),
      .stk_busy   (stk_busy)
   );

   // Behavioural LIFO standing in for the shared stack
   logic [DATA-1:0] mem [DEPTH];
   int              sp = 0;
   always @(posedge clk) begin
      if (reset || !stk_flush_) sp <= 0;
      else if (!stk_push_) begin
         if (sp < DEPTH) mem[sp] <= stk_wd;
         sp <= sp + 1;
      end else if (!stk_pop_) sp <= sp - 1;
   end
   assign stk_v  = (sp > 0);
   assign stk_rd = (sp > 0) ? mem[sp-1] : '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_push = '0;
      bus.req_pop  = '0;
      flush        = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic push0(input logic [63:0] v);
      bus.req_push = 4'b0001;
      wd[0]        = v;
      step();
      idle();
   endtask

   task automatic chk_resp(input string tag, input logic [1:0] id, input logic [63:0] d, input logic e);
      chk({tag, "_vld"},  bus.resp_valid, 1'b1);
      chk({tag, "_id"},   bus.resp_id,    id);
      chk({tag, "_data"}, bus.resp_data,  d);
      chk({tag, "_err"},  bus.resp_err,   e);
   endtask

   initial begin
      stk_busy = 1'b0;
      for (int i = 0; i < REQ; i++) wd[i] = '0;
      do_reset();

      // Reset state, and idle outputs while reset is held
      chk("rst_occ", occ, 0);
      chk("rst_vld", bus.resp_valid, 0);
      chk("rst_id", bus.resp_id, 0);
      chk("rst_data", bus.resp_data, 0);
      chk("rst_err", bus.resp_err, 0);
      reset = 1'b1;
      bus.req_push = 4'b0001;
      #1;
      chk("rst_gnt", bus.req_gnt, 0);
      chk("rst_push_", stk_push_, 1);
      chk("rst_pop_", stk_pop_, 1);
      chk("rst_flush_", stk_flush_, 1);
      do_reset();

      // Single push
      bus.req_push = 4'b0001;
      wd[0] = 64'hA5;
      #1;
      chk("p1_gnt", bus.req_gnt, 4'b0001);
      chk("p1_push_", stk_push_, 0);
      chk("p1_wd", stk_wd, 64'hA5);
      step();
      idle();
      chk("p1_occ", occ, 1);
      chk("p1_novld", bus.resp_valid, 0);

      // Stack busy blocks the push but not a pop from another requester
      stk_busy = 1'b1;
      bus.req_push = 4'b0001;
      bus.req_pop  = 4'b0010;
      #1;
      chk("busy_gnt", bus.req_gnt, 4'b0010);
      chk("busy_pop_", stk_pop_, 0);
      step();
      idle();
      stk_busy = 1'b0;
      chk_resp("busy", 2'd1, 64'hA5, 1'b0);
      chk("busy_occ", occ, 0);

      // Push then pop from another requester
      do_reset();
      push0(64'h11);
      bus.req_pop = 4'b0100;
      #1;
      chk("pp_gnt", bus.req_gnt, 4'b0100);
      chk("pp_pop_", stk_pop_, 0);
      step();
      idle();
      chk_resp("pp", 2'd2, 64'h11, 1'b0);
      chk("pp_occ", occ, 0);
      step();
      chk("pp_vld_drop", bus.resp_valid, 0);
      chk("pp_data_hold", bus.resp_data, 64'h11);

      // All requesters pop an empty stack: round-robin underflow responses
      do_reset();
      bus.req_pop = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("uf_gnt", bus.req_gnt, 4'b0001 << (k % 4));
         chk("uf_pop_", stk_pop_, 1);
         step();
         chk_resp("uf", 2'(k % 4), 64'h0, 1'b1);
         chk("uf_occ", occ, 0);
      end
      idle();

      // Full stack: pusher skipped, popper served, pusher granted next
      do_reset();
      for (int k = 0; k < DEPTH; k++) push0(64'h100 + 64'(k));
      chk("full_occ", occ, 8);
      bus.req_push = 4'b0010;
      bus.req_pop  = 4'b1000;
      wd[1] = 64'hBEEF;
      #1;
      chk("full_gnt", bus.req_gnt, 4'b1000);
      chk("full_push_", stk_push_, 1);
      chk("full_pop_", stk_pop_, 0);
      step();
      bus.req_pop = 4'b0000;
      chk_resp("full", 2'd3, 64'h107, 1'b0);
      chk("full_occ7", occ, 7);
      #1;
      chk("full_gnt1", bus.req_gnt, 4'b0010);
      step();
      idle();
      chk("full_occ8", occ, 8);

      // Push and pop from the same requester: push wins, pop later
      do_reset();
      push0(64'h1);
      push0(64'h2);
      push0(64'h3);
      bus.req_push = 4'b0100;
      bus.req_pop  = 4'b0100;
      wd[2] = 64'h55;
      #1;
      chk("both_gnt", bus.req_gnt, 4'b0100);
      chk("both_push_", stk_push_, 0);
      chk("both_pop_", stk_pop_, 1);
      step();
      bus.req_push = 4'b0000;
      chk("both_occ", occ, 4);
      chk("both_novld", bus.resp_valid, 0);
      #1;
      chk("both_gnt2", bus.req_gnt, 4'b0100);
      step();
      idle();
      chk_resp("both", 2'd2, 64'h55, 1'b0);
      chk("both_occ3", occ, 3);

      // Flush with a response in flight and requests pending
      do_reset();
      for (int k = 0; k < 5; k++) push0(64'h20 + 64'(k));
      bus.req_pop = 4'b1000;
      step();
      chk_resp("prefl", 2'd3, 64'h24, 1'b0);
      chk("prefl_occ", occ, 4);
      bus.req_push = 4'b0001;
      bus.req_pop  = 4'b0100;
      flush = 1'b1;
      #1;
      chk("fl_gnt", bus.req_gnt, 0);
      chk("fl_flush_", stk_flush_, 0);
      chk("fl_push_", stk_push_, 1);
      chk("fl_pop_", stk_pop_, 1);
      chk("fl_vld_kept", bus.resp_valid, 1);
      step();
      idle();
      chk("fl_occ", occ, 0);
      chk("fl_vld", bus.resp_valid, 0);
      bus.req_pop = 4'b0010;
      #1;
      chk("aft_gnt", bus.req_gnt, 4'b0010);
      chk("aft_pop_", stk_pop_, 1);
      step();
      idle();
      chk_resp("aft", 2'd1, 64'h0, 1'b1);

      // Reset mid-stream with a pop pending
      push0(64'h77);
      push0(64'h78);
      chk("mr_occ2", occ, 2);
      bus.req_pop = 4'b0001;
      reset = 1'b1;
      #1;
      chk("mr_gnt", bus.req_gnt, 0);
      chk("mr_pop_", stk_pop_, 1);
      step();
      reset = 1'b0;
      idle();
      chk("mr_occ", occ, 0);
      chk("mr_vld", bus.resp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
